// File: rtl/temp_fifo_avg.sv
// temp_fifo_avg: buffers 8-bit temperature samples in a small FIFO and
// drains them into a windowed averager with a valid/ready output.
// Each average is compared against an alarm threshold. Writes that arrive
// while the FIFO is full are dropped and latched in a sticky overflow flag.
module temp_fifo_avg #(
    parameter int         DEPTH       = 8,
    parameter int         ADDR_W      = 3,
    parameter int         AVG_SHIFT   = 2,
    parameter logic [7:0] ALARM_LEVEL = 8'd200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_fifo_en,
    input  logic [7:0]      data_to_fifo,
    output logic            fifo_full,
    output logic            fifo_empty,
    output logic [ADDR_W:0] fifo_count,
    output logic            overflow,
    output logic [7:0]      avg_data,
    output logic            avg_valid,
    input  logic            avg_ready,
    output logic            alarm
);

    // Accumulator holds AVG_N samples of 8 bits without overflow.
    localparam int ACC_W = 8 + AVG_SHIFT;
    // The counter is one bit wider than strictly needed so AVG_SHIFT = 0
    // still yields a legal non-zero width.
    localparam int CNT_W = AVG_SHIFT + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((2 ** AVG_SHIFT) - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    // Storage: no reset, contents are only meaningful between the pointers.
    logic [7:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        avg_data_q, avg_data_d;
    logic              avg_valid_q, avg_valid_d;
    logic              alarm_q, alarm_d;

    logic              push;
    logic              pop;
    logic [7:0]        sample;
    logic [ACC_W-1:0]  sum;
    logic [7:0]        avg_now;

    // Flags come straight from the registered count, so a freshly written
    // sample is only visible to the reader one cycle later.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign avg_data   = avg_data_q;
    assign avg_valid  = avg_valid_q;
    assign alarm      = alarm_q;

    assign push    = wr_fifo_en && !fifo_full;
    assign pop     = (state_q == ACCUM) && !fifo_empty;
    assign sample  = mem[rd_ptr_q];
    assign sum     = acc_q + ACC_W'(sample);
    assign avg_now = sum[ACC_W-1:AVG_SHIFT];

    // Sample storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data_to_fifo;
        end
    end

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_fifo_en && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // Averager: accumulate AVG_N pops, present the mean, wait for handshake.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_data_d  = avg_data_q;
        avg_valid_d = avg_valid_q;
        alarm_d     = alarm_q;
        case (state_q)
            ACCUM: begin
                if (pop) begin
                    if (cnt_q == LAST_CNT) begin
                        avg_data_d  = avg_now;
                        avg_valid_d = 1'b1;
                        alarm_d     = (avg_now >= ALARM_LEVEL);
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = OUT;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                if (avg_valid_q && avg_ready) begin
                    avg_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State registers; reset discards FIFO contents and partial windows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_data_q  <= '0;
            avg_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_data_q  <= avg_data_d;
            avg_valid_q <= avg_valid_d;
            alarm_q     <= alarm_d;
        end
    end

endmodule

// File: tb/tb_temp_fifo_avg.sv
// Bench for temp_fifo_avg: directed writes, expected averages queued by the
// stimulus and checked by an independent handshake monitor.
module tb_temp_fifo_avg;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_fifo_en;
    logic [7:0] data_to_fifo;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] avg_data;
    logic       avg_valid;
    logic       avg_ready;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    // {alarm, avg_data} expected for each future handshake
    logic [8:0] exp_q [$];

    temp_fifo_avg dut (
        .clk          (clk),
        .reset        (reset),
        .wr_fifo_en   (wr_fifo_en),
        .data_to_fifo (data_to_fifo),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .avg_data     (avg_data),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    // One write strobe, entered and left at a falling edge.
    task automatic wr(input logic [7:0] d);
        wr_fifo_en   = 1'b1;
        data_to_fifo = d;
        @(negedge clk);
        wr_fifo_en   = 1'b0;
    endtask

    task automatic expect_avg(input logic [7:0] d, input logic a);
        exp_q.push_back({a, d});
    endtask

    // Monitor: a handshake will occur at the next rising edge.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && avg_valid && avg_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_avg: got %0d expected none", avg_data);
                end else begin
                    e = exp_q.pop_front();
                    check("avg_data", int'(avg_data), int'(e[7:0]));
                    check("avg_alarm", int'(alarm), int'(e[8]));
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        wr_fifo_en   = 1'b0;
        data_to_fifo = 8'd0;
        avg_ready    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_count", int'(fifo_count), 0);
        check("rst_empty", int'(fifo_empty), 1);
        check("rst_full", int'(fifo_full), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_valid", int'(avg_valid), 0);
        check("rst_avg_data", int'(avg_data), 0);
        check("rst_alarm", int'(alarm), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: basic mean
        expect_avg(8'd25, 1'b0);
        wr(8'd10); wr(8'd20); wr(8'd30); wr(8'd40);
        repeat (6) @(negedge clk);
        check("t1_empty", int'(fifo_empty), 1);
        check("t1_count", int'(fifo_count), 0);
        check("t1_valid_pulse_done", int'(avg_valid), 0);

        // 2: truncating division
        expect_avg(8'd1, 1'b0);
        wr(8'd1); wr(8'd2); wr(8'd2); wr(8'd2);
        repeat (6) @(negedge clk);

        // 3: backpressure, fill, overflow
        avg_ready = 1'b0;
        expect_avg(8'd225, 1'b1);
        expect_avg(8'd100, 1'b0);
        expect_avg(8'd50, 1'b0);
        wr(8'd210); wr(8'd220); wr(8'd230); wr(8'd240);
        for (int i = 0; i < 4; i++) wr(8'd100);
        for (int i = 0; i < 4; i++) wr(8'd50);
        check("t3_count_full", int'(fifo_count), 8);
        check("t3_full", int'(fifo_full), 1);
        check("t3_overflow_pre", int'(overflow), 0);
        wr(8'd77);
        check("t3_count_after_drop", int'(fifo_count), 8);
        check("t3_overflow", int'(overflow), 1);
        check("t3_valid", int'(avg_valid), 1);
        check("t3_avg_data", int'(avg_data), 225);
        check("t3_alarm", int'(alarm), 1);
        repeat (3) @(negedge clk);
        check("t3_hold_data", int'(avg_data), 225);
        check("t3_hold_valid", int'(avg_valid), 1);

        // 4: write while full during a pop is still rejected
        avg_ready = 1'b1;
        @(negedge clk);
        check("t4_full_in_accum", int'(fifo_full), 1);
        wr(8'd99);
        check("t4_count_7", int'(fifo_count), 7);
        check("t4_alarm_held", int'(alarm), 1);
        check("t4_overflow_sticky", int'(overflow), 1);
        repeat (16) @(negedge clk);
        check("t4_drained", int'(fifo_empty), 1);

        // 5: concurrent write and pop, pointer wrap
        expect_avg(8'd1, 1'b0);
        expect_avg(8'd5, 1'b0);
        expect_avg(8'd9, 1'b0);
        expect_avg(8'd13, 1'b0);
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            if (i == 2) check("t5_count_w3", int'(fifo_count), 1);
            if (i == 3) check("t5_count_w4", int'(fifo_count), 1);
            if (i == 9) check("t5_count_w10", int'(fifo_count), 2);
            if (i == 15) check("t5_count_w16", int'(fifo_count), 4);
        end
        repeat (10) @(negedge clk);

        // 6: reset mid-window
        wr(8'd50); wr(8'd50); wr(8'd50);
        reset = 1'b1;
        #1;
        check("t6_count", int'(fifo_count), 0);
        check("t6_empty", int'(fifo_empty), 1);
        check("t6_overflow", int'(overflow), 0);
        check("t6_valid", int'(avg_valid), 0);
        check("t6_avg_data", int'(avg_data), 0);
        check("t6_alarm", int'(alarm), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_avg(8'd100, 1'b0);
        for (int i = 0; i < 4; i++) wr(8'd100);
        repeat (6) @(negedge clk);

        // alarm threshold boundary: average exactly at the level
        expect_avg(8'd200, 1'b1);
        for (int i = 0; i < 4; i++) wr(8'd200);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("end_pending_avgs", exp_q.size(), 0);
        check("end_empty", int'(fifo_empty), 1);
        check("end_alarm", int'(alarm), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
